controller_fsm_rx: RTL and testbench

Receive-side system controller. Parses bytes from the UART RX deserializer into command frames and sequences the shared datapath: register-file writes and reads, ALU operand loading and ALU execution, and the ALU clock-gate enable. It sits between the UART RX output and the register file / ALU. Results reach the UART TX path through the existing TX controller, using the register file's RdData_VLD and the ALU's ALU_OUT_VLD.

---
 rtl/controller_fsm_rx.sv | 174 +++++++++++++++++
 tb/tb_controller_fsm_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_fsm_rx.sv
// Purpose : receive-side controller; decodes UART RX bytes into write/read/ALU frames and drives RF/ALU strobes.
// Latency : every strobe and its data appear exactly one cycle after the RX_D_VLD cycle that causes them.
// Backpr. : none; bytes are accepted on any cycle except ALU_HOLD, where an arriving byte is dropped with FRAME_ERR.
//
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   RX_P_Data, RX_D_VLD received byte and its one-cycle strobe
//   RF_Address, RF_WrData, RF_WrEn, RF_RdEn   register-file access (data held between strobes)
//   ALU_FUN, ALU_EN, CLK_GATE_EN              ALU function, execute strobe, gated-clock enable
//   FRAME_ERR           one-cycle pulse on unknown command, byte during ALU_HOLD, or inter-byte timeout
module controller_fsm_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_Data,
    input  logic                  RX_D_VLD,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    output logic                  CLK_GATE_EN,
    output logic                  FRAME_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OP_A, S_OP_B, S_ALU_FUN, S_ALU_HOLD
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_lat, addr_lat_nxt;   // write address held between WR_ADDR and WR_DATA
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdat_nxt;
    logic [FUN_WIDTH-1:0]  fun_nxt;
    logic                  wren_nxt, rden_nxt, aluen_nxt, ferr_nxt, gate_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_lat    <= '0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            addr_lat    <= addr_lat_nxt;
            RF_Address  <= addr_nxt;
            RF_WrData   <= wdat_nxt;
            RF_WrEn     <= wren_nxt;
            RF_RdEn     <= rden_nxt;
            ALU_FUN     <= fun_nxt;
            ALU_EN      <= aluen_nxt;
            CLK_GATE_EN <= gate_nxt;
            FRAME_ERR   <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_lat_nxt = addr_lat;
        addr_nxt     = RF_Address;
        wdat_nxt     = RF_WrData;
        fun_nxt      = ALU_FUN;
        wren_nxt     = 1'b0;
        rden_nxt     = 1'b0;
        aluen_nxt    = 1'b0;
        ferr_nxt     = 1'b0;

        // Inter-byte timeout: only mid-frame, and a byte in the expiry cycle wins.
        if (state != S_IDLE && state != S_ALU_HOLD && !RX_D_VLD) begin
            if (cnt == CNT_LAST) begin
                state_nxt = S_IDLE;
                ferr_nxt  = 1'b1;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
        if (RX_D_VLD) begin
            cnt_nxt = '0;
        end

        case (state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_Data)
                        CMD_WR:     state_nxt = S_WR_ADDR;
                        CMD_RD:     state_nxt = S_RD_ADDR;
                        CMD_ALU_OP: state_nxt = S_OP_A;
                        CMD_ALU_NO: state_nxt = S_ALU_FUN;
                        default:    ferr_nxt  = 1'b1;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_lat_nxt = RX_P_Data[ADDR_WIDTH-1:0];
                    state_nxt    = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    addr_nxt  = addr_lat;
                    wdat_nxt  = RX_P_Data;
                    wren_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_nxt  = RX_P_Data[ADDR_WIDTH-1:0];
                    rden_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_OP_A: begin
                if (RX_D_VLD) begin
                    addr_nxt  = '0;
                    wdat_nxt  = RX_P_Data;
                    wren_nxt  = 1'b1;
                    state_nxt = S_OP_B;
                end
            end
            S_OP_B: begin
                if (RX_D_VLD) begin
                    addr_nxt  = ADDR_WIDTH'(1);
                    wdat_nxt  = RX_P_Data;
                    wren_nxt  = 1'b1;
                    state_nxt = S_ALU_FUN;
                end
            end
            S_ALU_FUN: begin
                if (RX_D_VLD) begin
                    fun_nxt   = RX_P_Data[FUN_WIDTH-1:0];
                    aluen_nxt = 1'b1;
                    state_nxt = S_ALU_HOLD;
                end
            end
            S_ALU_HOLD: begin
                // Gives the ALU its execute cycle under the gated clock; a byte here is lost.
                state_nxt = S_IDLE;
                ferr_nxt  = RX_D_VLD;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Gate follows the registered state: high exactly while an ALU frame is in flight.
        gate_nxt = (state_nxt == S_OP_A) || (state_nxt == S_OP_B) ||
                   (state_nxt == S_ALU_FUN) || (state_nxt == S_ALU_HOLD);
    end

endmodule

// File: tb/tb_controller_fsm_rx.sv
// Purpose : self-checking bench for controller_fsm_rx; frame-level reference model feeds a scoreboard.
// Latency : expected strobes are due one step after the byte that causes them.
// Backpr. : none; the driver issues bytes freely, including during ALU_HOLD.
module tb_controller_fsm_rx;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int T  = 16;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ALU = 2;
    localparam int K_ERR = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] RX_P_Data = '0;
    logic          RX_D_VLD = 1'b0;
    logic [AW-1:0] RF_Address;
    logic [DW-1:0] RF_WrData;
    logic          RF_WrEn;
    logic          RF_RdEn;
    logic [FW-1:0] ALU_FUN;
    logic          ALU_EN;
    logic          CLK_GATE_EN;
    logic          FRAME_ERR;

    controller_fsm_rx #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
        .RF_Address(RF_Address), .RF_WrData(RF_WrData), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
        .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [FW-1:0] fun;
        int            due;
    } ev_t;

    ev_t           exp_q[$];
    bit            exp_gate[int];
    int            step   = 0;
    int            checks = 0;
    int            errors = 0;

    // Reference model: the bytes of the frame collected so far, idle steps since the last byte,
    // and whether the previous byte completed an ALU frame (next step is the dead cycle).
    logic [DW-1:0] frame[$];
    int            idle_n = 0;
    bit            hold   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d act=%0h exp=%0h", name, step, act, exp);
        end
    endtask

    function automatic int frame_len(input logic [DW-1:0] cmd);
        case (cmd)
            8'hAA:   return 3;
            8'hBB:   return 2;
            8'hCC:   return 4;
            8'hDD:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input int kind);
        case (kind)
            K_WR:    return 4'b1000;
            K_RD:    return 4'b0100;
            K_ALU:   return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic push(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [FW-1:0] f);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.fun  = f;
        e.due  = step + 1;
        exp_q.push_back(e);
    endtask

    task automatic model(input bit v, input logic [DW-1:0] b);
        logic [DW-1:0] cmd;
        if (hold) begin
            hold = 1'b0;
            if (v) push(K_ERR, '0, '0, '0);
        end else if (frame.size() == 0) begin
            if (v) begin
                if (frame_len(b) > 0) begin
                    frame.push_back(b);
                    idle_n = 0;
                end else begin
                    push(K_ERR, '0, '0, '0);
                end
            end
        end else if (v) begin
            frame.push_back(b);
            idle_n = 0;
            cmd = frame[0];
            if (cmd == 8'hCC && frame.size() == 2) push(K_WR, 4'd0, b, '0);
            if (cmd == 8'hCC && frame.size() == 3) push(K_WR, 4'd1, b, '0);
            if (frame.size() == frame_len(cmd)) begin
                if (cmd == 8'hAA) begin
                    cmd = frame[1];
                    push(K_WR, cmd[AW-1:0], b, '0);
                end else if (cmd == 8'hBB) begin
                    push(K_RD, b[AW-1:0], '0, '0);
                end else begin
                    push(K_ALU, '0, '0, b[FW-1:0]);
                    hold = 1'b1;
                end
                frame.delete();
            end
        end else begin
            idle_n++;
            if (idle_n == T) begin
                push(K_ERR, '0, '0, '0);
                frame.delete();
                idle_n = 0;
            end
        end
        exp_gate[step + 1] = hold || (frame.size() > 0 && (frame[0] == 8'hCC || frame[0] == 8'hDD));
    endtask

    task automatic tick(input bit v, input logic [DW-1:0] b);
        RX_D_VLD  = v;
        RX_P_Data = v ? b : DW'($urandom);
        model(v, b);
        @(posedge CLK);
        step++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0);
    endtask

    task automatic do_reset();
        RST      = 1'b0;
        RX_D_VLD = 1'b0;
        exp_q.delete();
        frame.delete();
        exp_gate.delete();
        hold   = 1'b0;
        idle_n = 0;
        @(posedge CLK);
        step++;
        #1;
        RST = 1'b1;
        exp_gate[step] = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a strobe, independent of the driver.
    ev_t        mon_e;
    logic [3:0] strb;
    always @(negedge CLK) begin
        if (!RST) begin
            chk("reset_outputs",
                {RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_FUN, ALU_EN, CLK_GATE_EN, FRAME_ERR}, '0);
        end else begin
            strb = {RF_WrEn, RF_RdEn, ALU_EN, FRAME_ERR};
            if (strb != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", strb, 4'b0000);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind", strb, onehot(mon_e.kind));
                    chk("strobe_step", step, mon_e.due);
                    if (mon_e.kind == K_WR) begin
                        chk("wr_addr", RF_Address, mon_e.addr);
                        chk("wr_data", RF_WrData, mon_e.data);
                    end else if (mon_e.kind == K_RD) begin
                        chk("rd_addr", RF_Address, mon_e.addr);
                    end else if (mon_e.kind == K_ALU) begin
                        chk("alu_fun", ALU_FUN, mon_e.fun);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= step) begin
                mon_e = exp_q.pop_front();
                chk("missing_strobe", strb, onehot(mon_e.kind));
            end
            if (exp_gate.exists(step)) begin
                chk("clk_gate_en", CLK_GATE_EN, exp_gate[step]);
                exp_gate.delete(step);
            end
        end
    end

    logic [DW-1:0] rb;
    initial begin
        RST = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            step++;
            #1;
        end
        RST = 1'b1;
        exp_gate[step] = 1'b0;
        idle(2);

        // Write frame
        tick(1, 8'hAA); tick(1, 8'h05); tick(1, 8'h3C); idle(3);
        // Read frame, upper address bits ignored
        tick(1, 8'hBB); tick(1, 8'h1F); idle(3);
        // ALU with operands, back-to-back
        tick(1, 8'hCC); tick(1, 8'h12); tick(1, 8'h34); tick(1, 8'h02); idle(3);
        // ALU without operands, then an unknown command
        tick(1, 8'hDD); tick(1, 8'h07); idle(2); tick(1, 8'h55); idle(2);
        // Timeout mid-frame, then a normal read
        tick(1, 8'hAA); tick(1, 8'h03); idle(T + 2); tick(1, 8'hBB); tick(1, 8'h03); idle(3);
        // Byte arriving exactly in the expiry cycle is still accepted
        tick(1, 8'hAA); idle(T - 1); tick(1, 8'h09); tick(1, 8'hA5); idle(3);
        // Byte in the ALU dead cycle is dropped with an error
        tick(1, 8'hDD); tick(1, 8'h03); tick(1, 8'hBB); tick(1, 8'hBB); tick(1, 8'h02); idle(3);
        // Timeout during operand collection leaves the gate low afterwards
        tick(1, 8'hCC); tick(1, 8'h44); idle(T + 1); tick(1, 8'hDD); tick(1, 8'h0E); idle(3);
        // Reset mid-frame
        tick(1, 8'hCC); tick(1, 8'h12); idle(1);
        do_reset();
        tick(1, 8'hDD); tick(1, 8'h01); idle(3);

        // Randomized byte stream, biased toward valid command bytes, with occasional long gaps
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                idle(T - 2 + int'($urandom_range(0, 3)));
            end else if ($urandom_range(0, 3) == 0) begin
                tick(1'b0, '0);
            end else begin
                case ($urandom_range(0, 5))
                    0:       rb = 8'hAA;
                    1:       rb = 8'hBB;
                    2:       rb = 8'hCC;
                    3:       rb = 8'hDD;
                    default: rb = DW'($urandom);
                endcase
                tick(1'b1, rb);
            end
        end

        idle(T + 4);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
